muldiv_unit: RTL and testbench

- Parametrised iterative RV32M/RV64M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts one M-extension op (selected by funct3) per valid/ready handshake and produces the result after a multi-cycle shift-add or restoring-divide sequence.
- Returns the result with a writeback tag on a valid/ready output handshake, so the pipeline stalls or forwards on it.

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional feature macro MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
module muldiv_unit #(
  parameter int DWIDTH = 32,
  parameter int TAGW   = 5,
  parameter int CNTW   = $clog2(DWIDTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [TAGW-1:0]   tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic [TAGW-1:0]   tag_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [DWIDTH-1:0]   ZERO    = {DWIDTH{1'b0}};
  localparam logic [DWIDTH-1:0]   ONES    = {DWIDTH{1'b1}};
  localparam logic [DWIDTH-1:0]   MIN_VAL = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [2*DWIDTH-1:0] ZERO2   = {(2*DWIDTH){1'b0}};
  localparam logic [CNTW-1:0]     LAST    = CNTW'(DWIDTH - 1);
  localparam logic [CNTW-1:0]     CNT_ONE = CNTW'(1);

  state_t              state_r;
  logic [CNTW-1:0]     cnt_r;
  logic [2:0]          op_r;
  logic                neg_r;
  logic [DWIDTH-1:0]   opa_r;  // multiplicand or divisor magnitude
  logic [2*DWIDTH-1:0] acc_r;  // {product hi, lo} or {remainder, quotient}

  logic                is_div_s, sgn1_s, sgn2_s, neg_s, div_zero_s, div_ovf_s;
  logic [DWIDTH-1:0]   mag1_s, mag2_s, special_res_s;

  // Decode of the incoming request: magnitudes, result sign and special cases.
  always_comb begin
    is_div_s   = funct3_i[2];
    sgn1_s     = rs1_i[DWIDTH-1] & (funct3_i != F_MULHU) & (funct3_i != F_DIVU)
                 & (funct3_i != F_REMU);
    sgn2_s     = rs2_i[DWIDTH-1] & ((funct3_i == F_MUL) | (funct3_i == F_MULH)
                 | (funct3_i == F_DIV) | (funct3_i == F_REM));
    mag1_s     = sgn1_s ? (ZERO - rs1_i) : rs1_i;
    mag2_s     = sgn2_s ? (ZERO - rs2_i) : rs2_i;
    neg_s      = (funct3_i == F_REM) ? sgn1_s : (sgn1_s ^ sgn2_s);
    div_zero_s = is_div_s & (rs2_i == ZERO);
    div_ovf_s  = is_div_s & ~funct3_i[0] & (rs1_i == MIN_VAL) & (rs2_i == ONES);
    if (div_zero_s) begin
      special_res_s = funct3_i[1] ? rs1_i : ONES;
    end else begin
      special_res_s = funct3_i[1] ? ZERO : MIN_VAL;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DWIDTH-1:0] fast_prod_s, fast_fix_s;
  logic [DWIDTH-1:0]   fast_res_s;

  // Single-cycle product with sign correction and half selection.
  always_comb begin
    fast_prod_s = {ZERO, mag1_s} * {ZERO, mag2_s};
    fast_fix_s  = neg_s ? (ZERO2 - fast_prod_s) : fast_prod_s;
    fast_res_s  = (funct3_i == F_MUL) ? fast_fix_s[DWIDTH-1:0] : fast_fix_s[2*DWIDTH-1:DWIDTH];
  end
`endif

  logic [DWIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*DWIDTH-1:0] acc_next_s, prod_fix_s;
  logic [DWIDTH-1:0]   quo_s, rem_s, final_s;

  // One shift-add or restoring-divide step, plus sign-corrected final result.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*DWIDTH-1:DWIDTH]} + {1'b0, (acc_r[0] ? opa_r : ZERO)};
    div_shift_s = {acc_r[2*DWIDTH-1:DWIDTH], acc_r[DWIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opa_r};
    if (op_r[2]) begin
      if (!div_diff_s[DWIDTH]) begin
        acc_next_s = {div_diff_s[DWIDTH-1:0], acc_r[DWIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {div_shift_s[DWIDTH-1:0], acc_r[DWIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[DWIDTH-1:1]};
    end
    prod_fix_s = neg_r ? (ZERO2 - acc_next_s) : acc_next_s;
    quo_s      = neg_r ? (ZERO - acc_next_s[DWIDTH-1:0]) : acc_next_s[DWIDTH-1:0];
    rem_s      = neg_r ? (ZERO - acc_next_s[2*DWIDTH-1:DWIDTH]) : acc_next_s[2*DWIDTH-1:DWIDTH];
    case (op_r)
      F_MUL:                     final_s = prod_fix_s[DWIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU: final_s = prod_fix_s[2*DWIDTH-1:DWIDTH];
      F_DIV, F_DIVU:             final_s = quo_s;
      F_REM, F_REMU:             final_s = rem_s;
      default:                   final_s = ZERO;
    endcase
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      op_r    <= 3'b000;
      neg_r   <= 1'b0;
      opa_r   <= ZERO;
      acc_r   <= ZERO2;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      res_o   <= ZERO;
      tag_o   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            op_r    <= funct3_i;
            tag_o   <= tag_i;
            neg_r   <= neg_s;
            cnt_r   <= '0;
            opa_r   <= is_div_s ? mag2_s : mag1_s;
            acc_r   <= is_div_s ? {ZERO, mag1_s} : {ZERO, mag2_s};
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            if (div_zero_s || div_ovf_s) begin
              state_r <= DONE;
              valid_o <= 1'b1;
              res_o   <= special_res_s;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div_s) begin
              state_r <= DONE;
              valid_o <= 1'b1;
              res_o   <= fast_res_s;
`endif
            end else begin
              state_r <= BUSY;
            end
          end else begin
            ready_o <= 1'b1;
          end
        end
        BUSY: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST) begin
            state_r <= DONE;
            valid_o <= 1'b1;
            res_o   <= final_s;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_r <= IDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven directed bench for muldiv_unit (DWIDTH=32) plus handshake/reset sequences.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] rs1_i = 32'd0;
  logic [31:0] rs2_i = 32'd0;
  logic [4:0]  tag_i = 5'd0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] res_o;
  logic [4:0]  tag_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  muldiv_unit #(.DWIDTH(32), .TAGW(5)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    logic        spec;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] f3, input logic spec);
    if (spec) return 1;
    if (!f3[2] && FAST) return 1;
    return 33;
  endfunction

  // Issue one op, wait for the result, check it, then consume it.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp,
                        input int lat_exp);
    int lat;
    int wait_cnt;
    @(negedge clk);
    valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; tag_i = t;
    wait_cnt = 0;
    while (!ready_o && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check({name, "_ready"}, {63'd0, ready_o}, 64'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(lat_exp));
    check({name, "_res"}, {32'd0, res_o}, {32'd0, exp});
    check({name, "_tag"}, {59'd0, tag_o}, {59'd0, t});
    check({name, "_busy"}, {62'd0, busy_o, ready_o}, 64'd2);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check({name, "_drop"}, {62'd0, valid_o, ready_o}, 64'd1);
  endtask

  initial begin
    int stale;
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 1'b0};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       1'b0};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        1'b0};
    vecs[8]  = '{3'b100, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'b111, 32'h1234,     32'd0,        5'd12, 32'h1234,     1'b1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1'b1};
    vecs[12] = '{3'b000, 32'd3,        32'd4,        5'd15, 32'd12,       1'b0};
    vecs[13] = '{3'b011, 32'h12345678, 32'h10,       5'd16, 32'd1,        1'b0};
    vecs[14] = '{3'b101, 32'hFFFFFFFF, 32'd1,        5'd17, 32'hFFFFFFFF, 1'b0};
    vecs[15] = '{3'b110, 32'd7,        32'hFFFFFFFD, 5'd18, 32'd1,        1'b0};
    vecs[16] = '{3'b100, 32'd7,        32'hFFFFFFFD, 5'd19, 32'hFFFFFFFE, 1'b0};
    vecs[17] = '{3'b001, 32'hFFFFFFFF, 32'd1,        5'd20, 32'hFFFFFFFF, 1'b0};
    vecs[18] = '{3'b100, 32'h80000000, 32'd2,        5'd21, 32'hC0000000, 1'b0};
    vecs[19] = '{3'b000, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h80000000, 1'b0};
    vecs[20] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd23, 32'd0,        1'b0};
    vecs[21] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd24, 32'h80000000, 1'b0};

    #12;
    check("rst_outputs", {24'd0, ready_o, valid_o, busy_o, tag_o, res_o},
          {24'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", {62'd0, ready_o, busy_o}, 64'd2);

    for (int i = 0; i < 22; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag,
             vecs[i].exp, exp_lat(vecs[i].f3, vecs[i].spec));
    end

    // Backpressure: result held while ready_i low; no accept on the handshake edge.
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7; tag_i = 5'd25;
    @(posedge clk);
    #1 valid_i = 1'b0;
    stale = 0;
    while (!valid_o && stale < 200) begin
      @(negedge clk);
      stale++;
    end
    valid_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd6; rs2_i = 32'd7; tag_i = 5'd26;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", c), {24'd0, valid_o, ready_o, busy_o, tag_o, res_o},
            {24'd0, 1'b1, 1'b0, 1'b1, 5'd25, 32'd14});
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("bp_release", {61'd0, valid_o, ready_o, busy_o}, 64'd2);
    @(negedge clk);
    valid_i = 1'b0;
    check("bp_accept_next", {62'd0, ready_o, busy_o}, 64'd1);
    stale = 1;
    while (!valid_o && stale < 200) begin
      @(negedge clk);
      stale++;
    end
    check("bp_new_lat", 64'(stale), 64'(exp_lat(3'b000, 1'b0)));
    check("bp_new_res", {27'd0, tag_o, res_o}, {27'd0, 5'd26, 32'd42});
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;

    // Reset mid-divide aborts the op with no stale result afterwards.
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'h1000; rs2_i = 32'd3; tag_i = 5'd27;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("rst_mid", {24'd0, ready_o, valid_o, busy_o, tag_o, res_o},
             {24'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
    @(negedge clk);
    reset_n = 1'b1;
    ready_i = 1'b1;
    stale = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_o) stale++;
    end
    ready_i = 1'b0;
    check("rst_no_stale", 64'(stale), 64'd0);
    run_op("post_rst_mul", 3'b000, 32'd3, 32'd4, 5'd1, 32'd12, exp_lat(3'b000, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
